tone_scheduler: RTL and testbench

TONE_SCHEDULER -- requirements
Module: tone_scheduler

---
 rtl/tone_scheduler_pkg.sv | 37 +++
 rtl/tone_scheduler_if.sv | 26 ++
 rtl/tone_scheduler_prio_arbiter3.sv | 15 +
 rtl/tone_scheduler.sv | 167 ++++++++++++++++
 tb/tb_tone_scheduler.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/tone_scheduler_pkg.sv
// rtl/tone_scheduler_pkg.sv - shared constants, types and helpers for the tone scheduler
// Contents: FSM state encoding, requester indices, payload field widths,
//           latched payload struct and the note-duration helper.
package tone_scheduler_pkg;

  localparam int NUM_REQ = 3;
  localparam int NOTE_W  = 3;
  localparam int OCT_W   = 2;
  localparam int LEN_W   = 3;
  localparam int CNT_W   = 10;

  localparam logic [1:0] REQ_ALERT = 2'd0;
  localparam logic [1:0] REQ_PLAY  = 2'd1;
  localparam logic [1:0] REQ_FREE  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [OCT_W-1:0]  oct;
    logic [LEN_W-1:0]  len;
  } payload_t;

  // Note length in ms for a length code; callers keep UNIT_MS*8 <= 1023 so
  // the result always fits the 10-bit ms counter.
  function automatic logic [CNT_W-1:0] note_ticks(input logic [LEN_W-1:0] len,
                                                   input int unit_ms);
    int t;
    t = (int'(len) + 1) * unit_ms;
    return t[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/tone_scheduler_if.sv
// rtl/tone_scheduler_if.sv - requester-side handshake bundle of the tone scheduler
// Signals: req_valid[3], req_note[3x3], req_oct[3x2], req_len[3x3] from the
//          requesters; req_ready[3], done[3], aborted back to them.
// Modports: master = requester side, slave = scheduler side.
interface tone_scheduler_if;
  import tone_scheduler_pkg::*;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*NOTE_W-1:0] req_note;
  logic [NUM_REQ*OCT_W-1:0]  req_oct;
  logic [NUM_REQ*LEN_W-1:0]  req_len;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        done;
  logic                      aborted;

  modport master (
    output req_valid, req_note, req_oct, req_len,
    input  req_ready, done, aborted
  );

  modport slave (
    input  req_valid, req_note, req_oct, req_len,
    output req_ready, done, aborted
  );

endinterface

// File: rtl/tone_scheduler_prio_arbiter3.sv
// rtl/tone_scheduler_prio_arbiter3.sv - fixed-priority 3-way grant, index 0 highest
// Ports: req_i[2:0] request vector in, gnt_o[2:0] one-hot grant out (combinational).
module prio_arbiter3 (
  input  logic [2:0] req_i,
  output logic [2:0] gnt_o
);

  always_comb begin
    gnt_o = 3'b000;
    if (req_i[0])      gnt_o = 3'b001;
    else if (req_i[1]) gnt_o = 3'b010;
    else if (req_i[2]) gnt_o = 3'b100;
  end

endmodule

// File: rtl/tone_scheduler.sv
// rtl/tone_scheduler.sv - shares one sound generator among three note requesters
// Ports: clk, rst (sync, active-high), tick_1ms (1 ms strobe), flush (abort note),
//        req_if (slave handshake bundle), tone_en/tone_note/tone_oct (generator
//        drive), busy (PLAY or GAP), owner (current owner index).
// Macro: TONE_SCHEDULER_PREEMPT_EN lets requester 0 preempt requesters 1 and 2.
module tone_scheduler
  import tone_scheduler_pkg::*;
#(
  parameter int UNIT_MS = 125,
  parameter int GAP_MS  = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_1ms,
  input  logic              flush,
  tone_scheduler_if.slave   req_if,
  output logic              tone_en,
  output logic [NOTE_W-1:0] tone_note,
  output logic [OCT_W-1:0]  tone_oct,
  output logic              busy,
  output logic [1:0]        owner
);

  localparam logic [CNT_W-1:0] GAP_TICKS = CNT_W'(GAP_MS);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  payload_t           pay_q, pay_d;
  logic [1:0]         owner_q, owner_d;
  logic               tone_en_q, tone_en_d;
  logic [NOTE_W-1:0]  tone_note_q, tone_note_d;
  logic [OCT_W-1:0]   tone_oct_q, tone_oct_d;
  logic               busy_q, busy_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               aborted_q, aborted_d;

  logic [2:0]         gnt;
  logic [2:0]         ready_c;
  logic               take;
  logic [1:0]         take_idx;
  logic [CNT_W-1:0]   play_ticks;

  prio_arbiter3 u_arb (
    .req_i (req_if.req_valid),
    .gnt_o (gnt)
  );

  assign play_ticks = note_ticks(pay_q.len, UNIT_MS);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pay_d     = pay_q;
    owner_d   = owner_q;
    done_d    = '0;
    aborted_d = 1'b0;
    ready_c   = 3'b000;
    take      = 1'b0;
    take_idx  = gnt[0] ? REQ_ALERT : (gnt[1] ? REQ_PLAY : REQ_FREE);

    case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          ready_c = gnt;
          take    = 1'b1;
        end
      end
      ST_PLAY, ST_GAP: begin
        if (flush) begin
          done_d[owner_q] = 1'b1;
          aborted_d       = 1'b1;
          state_d         = ST_IDLE;
          cnt_d           = '0;
        end
`ifdef TONE_SCHEDULER_PREEMPT_EN
        else if (req_if.req_valid[0] && (owner_q != REQ_ALERT)) begin
          done_d[owner_q] = 1'b1;
          aborted_d       = 1'b1;
          ready_c         = 3'b001;
          take            = 1'b1;
          take_idx        = REQ_ALERT;
        end
`endif
        else if (state_q == ST_PLAY) begin
          // The tick that completes the note also ends PLAY, so the tone is
          // heard across exactly (len+1)*UNIT_MS ticks.
          if (tick_1ms) begin
            if (cnt_q + 10'd1 == play_ticks) begin
              state_d = ST_GAP;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 10'd1;
            end
          end
        end else begin
          // Counter parks at GAP_TICKS for one cycle: that is the final GAP
          // cycle carrying the registered done pulse.
          if (cnt_q == GAP_TICKS) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (tick_1ms) begin
            cnt_d = cnt_q + 10'd1;
            if (cnt_q + 10'd1 == GAP_TICKS) done_d[owner_q] = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (take) begin
      state_d      = ST_PLAY;
      cnt_d        = '0;
      owner_d      = take_idx;
      pay_d.note   = req_if.req_note[take_idx*NOTE_W +: NOTE_W];
      pay_d.oct    = req_if.req_oct[take_idx*OCT_W +: OCT_W];
      pay_d.len    = req_if.req_len[take_idx*LEN_W +: LEN_W];
    end

    // Generator drive is registered from the next state so it changes on the
    // same edge as the FSM.
    tone_en_d   = (state_d == ST_PLAY) && (pay_d.note != '0);
    tone_note_d = (state_d == ST_PLAY) ? pay_d.note : '0;
    tone_oct_d  = (state_d == ST_PLAY) ? pay_d.oct  : '0;
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pay_q       <= '0;
      owner_q     <= '0;
      tone_en_q   <= 1'b0;
      tone_note_q <= '0;
      tone_oct_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= '0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pay_q       <= pay_d;
      owner_q     <= owner_d;
      tone_en_q   <= tone_en_d;
      tone_note_q <= tone_note_d;
      tone_oct_q  <= tone_oct_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
    end
  end

  // Ready must pulse in the acceptance cycle, so it stays combinational;
  // reset masks it.
  assign req_if.req_ready = rst ? 3'b000 : ready_c;
  assign req_if.done      = done_q;
  assign req_if.aborted   = aborted_q;
  assign tone_en          = tone_en_q;
  assign tone_note        = tone_note_q;
  assign tone_oct         = tone_oct_q;
  assign busy             = busy_q;
  assign owner            = owner_q;

endmodule

// File: tb/tb_tone_scheduler.sv
// tb/tb_tone_scheduler.sv - directed self-checking bench for tone_scheduler
module tb_tone_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1ms = 1'b0;
  logic       flush = 1'b0;
  logic       tone_en;
  logic [2:0] tone_note;
  logic [1:0] tone_oct;
  logic       busy;
  logic [1:0] owner;

  int n_tests = 0;
  int n_fail  = 0;

  tone_scheduler_if rif ();

  tone_scheduler #(.UNIT_MS(125), .GAP_MS(20)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick_1ms  (tick_1ms),
    .flush     (flush),
    .req_if    (rif),
    .tone_en   (tone_en),
    .tone_note (tone_note),
    .tone_oct  (tone_oct),
    .busy      (busy),
    .owner     (owner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic [2:0] note, input logic [1:0] oct,
                         input logic [2:0] len);
    rif.req_note[idx*3 +: 3] = note;
    rif.req_oct[idx*2 +: 2]  = oct;
    rif.req_len[idx*3 +: 3]  = len;
  endtask

  function automatic logic [15:0] all_outs();
    return {tone_en, tone_note, tone_oct, busy, owner, rif.req_ready, rif.done, rif.aborted};
  endfunction

  task automatic run_ticks(input int n, output int on);
    on = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); tick_1ms = 1'b1; #1;
      if (tone_en) on++;
      repeat (3) begin @(negedge clk); tick_1ms = 1'b0; end
    end
  endtask

  // Ticks every 4th cycle until a done pulse is observed; returns at #1 inside
  // the done cycle.
  task automatic measure(input logic [2:0] exp_note, output int on, output int off,
                         output logic [2:0] dn, output logic ab);
    bit seen;
    int bad;
    seen = 0; bad = 0; on = 0; off = 0; dn = '0; ab = 1'b0;
    for (int c = 0; c < 6000 && !seen; c++) begin
      @(negedge clk); tick_1ms = (c % 4 == 0); #1;
      if (tone_en ? (tone_note !== exp_note) : (tone_note !== 3'd0)) bad++;
      if (tick_1ms && tone_en) on++;
      if (tick_1ms && busy && !tone_en) off++;
      if (rif.done !== 3'b000) begin seen = 1; dn = rif.done; ab = rif.aborted; end
    end
    tick_1ms = 1'b0;
    check("done_seen", 32'(seen), 32'd1);
    check("note_rule", bad, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int on, off, cnt_done, cnt_busy;
    logic [2:0] dn;
    logic ab;
    rif.req_valid = 3'b000;
    rif.req_note  = '0;
    rif.req_oct   = '0;
    rif.req_len   = '0;

    // reset state
    repeat (3) @(negedge clk);
    #1 check("reset_outs", 32'(all_outs()), 32'd0);
    @(negedge clk); rst = 1'b0;

    // single playback note
    @(negedge clk);
    set_req(1, 3'd5, 2'd2, 3'd0); rif.req_valid = 3'b010; #1;
    check("s1_ready", 32'(rif.req_ready), 32'b010);
    @(negedge clk); rif.req_valid = 3'b000; #1;
    check("s1_play", 32'({tone_en, tone_note, tone_oct, busy, owner}), 32'({1'b1, 3'd5, 2'd2, 1'b1, 2'd1}));
    measure(3'd5, on, off, dn, ab);
    check("s1_on", on, 125);
    check("s1_off", off, 20);
    check("s1_done", 32'({dn, ab}), 32'({3'b010, 1'b0}));
    check("s1_busy_in_done", 32'(busy), 32'd1);
    @(negedge clk); #1;
    check("s1_idle", 32'({busy, rif.done}), 32'd0);

    // simultaneous requests 1 and 2
    @(negedge clk);
    set_req(1, 3'd3, 2'd0, 3'd0); set_req(2, 3'd6, 2'd1, 3'd0);
    rif.req_valid = 3'b110; #1;
    check("s2_ready1", 32'(rif.req_ready), 32'b010);
    @(negedge clk); rif.req_valid = 3'b100; #1;
    check("s2_wait", 32'(rif.req_ready), 32'b000);
    measure(3'd3, on, off, dn, ab);
    check("s2_done1", 32'(dn), 32'b010);
    check("s2_no_ready_in_done", 32'(rif.req_ready), 32'b000);
    @(negedge clk); #1;
    check("s2_ready2", 32'(rif.req_ready), 32'b100);
    @(negedge clk); rif.req_valid = 3'b000; #1;
    check("s2_play2", 32'({owner, tone_note, tone_oct}), 32'({2'd2, 3'd6, 2'd1}));
    measure(3'd6, on, off, dn, ab);
    check("s2_on2", on, 125);
    check("s2_done2", 32'({dn, ab}), 32'({3'b100, 1'b0}));

    // long note flushed at tick 300
    @(negedge clk);
    set_req(1, 3'd4, 2'd1, 3'd7); rif.req_valid = 3'b010; #1;
    check("s3_ready", 32'(rif.req_ready), 32'b010);
    @(negedge clk); rif.req_valid = 3'b000;
    run_ticks(300, on);
    check("s3_on", on, 300);
    @(negedge clk); flush = 1'b1; #1;
    check("s3_en_before", 32'(tone_en), 32'd1);
    @(negedge clk); flush = 1'b0; #1;
    check("s3_flushed", 32'({tone_en, tone_note, busy, rif.done, rif.aborted}), 32'({1'b0, 3'd0, 1'b0, 3'b010, 1'b1}));
    @(negedge clk); #1;
    check("s3_pulse_end", 32'({rif.done, rif.aborted}), 32'd0);

    // flush in IDLE is ignored
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0; #1;
    check("idle_flush", 32'({busy, rif.done, rif.aborted}), 32'd0);

    // beep during a free-play note
    @(negedge clk);
    set_req(2, 3'd2, 2'd0, 3'd0); rif.req_valid = 3'b100; #1;
    check("s4_ready2", 32'(rif.req_ready), 32'b100);
    @(negedge clk); rif.req_valid = 3'b000;
    run_ticks(50, on);
    check("s4_on50", on, 50);
    @(negedge clk);
    set_req(0, 3'd7, 2'd3, 3'd0); rif.req_valid = 3'b001; #1;
`ifdef TONE_SCHEDULER_PREEMPT_EN
    check("s4_preempt_ready", 32'(rif.req_ready), 32'b001);
    @(negedge clk); rif.req_valid = 3'b000; #1;
    check("s4_victim", 32'({rif.done, rif.aborted, owner, tone_en, tone_note}), 32'({3'b100, 1'b1, 2'd0, 1'b1, 3'd7}));
    measure(3'd7, on, off, dn, ab);
    check("s4_beep_on", on, 125);
    check("s4_beep_off", off, 20);
    check("s4_beep_done", 32'({dn, ab}), 32'({3'b001, 1'b0}));
`else
    check("s4_beep_waits", 32'(rif.req_ready), 32'b000);
    measure(3'd2, on, off, dn, ab);
    check("s4_rest_on", on, 75);
    check("s4_free_done", 32'({dn, ab}), 32'({3'b100, 1'b0}));
    check("s4_no_ready_in_done", 32'(rif.req_ready), 32'b000);
    @(negedge clk); #1;
    check("s4_ready0", 32'(rif.req_ready), 32'b001);
    @(negedge clk); rif.req_valid = 3'b000; #1;
    check("s4_beep_play", 32'({owner, tone_note, tone_oct}), 32'({2'd0, 3'd7, 2'd3}));
    measure(3'd7, on, off, dn, ab);
    check("s4_beep_on", on, 125);
    check("s4_beep_done", 32'({dn, ab}), 32'({3'b001, 1'b0}));
`endif

    // rest note, len 1
    @(negedge clk);
    set_req(2, 3'd0, 2'd0, 3'd1); rif.req_valid = 3'b100; #1;
    check("s5_ready", 32'(rif.req_ready), 32'b100);
    @(negedge clk); rif.req_valid = 3'b000; #1;
    check("s5_silent_busy", 32'({tone_en, busy}), 32'b01);
    measure(3'd0, on, off, dn, ab);
    check("s5_on", on, 0);
    check("s5_off", off, 270);
    check("s5_done", 32'({dn, ab}), 32'({3'b100, 1'b0}));

    // reset mid-note
    @(negedge clk);
    set_req(1, 3'd1, 2'd1, 3'd3); rif.req_valid = 3'b010; #1;
    check("s6_ready", 32'(rif.req_ready), 32'b010);
    @(negedge clk); rif.req_valid = 3'b000;
    run_ticks(10, on);
    check("s6_on", on, 10);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); #1;
    check("s6_reset_outs", 32'(all_outs()), 32'd0);
    rst = 1'b0;
    cnt_done = 0; cnt_busy = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk); tick_1ms = (c % 4 == 0); #1;
      if (rif.done !== 3'b000) cnt_done++;
      if (busy !== 1'b0) cnt_busy++;
    end
    tick_1ms = 1'b0;
    check("s6_no_done", cnt_done, 0);
    check("s6_no_busy", cnt_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
